sram_pdp_arb: RTL

Two-requester arbiter that shares the pseudo-dual-port SRAM (`sram_pdp`) between two clients. The write port (A) and the read port (B) are arbitrated independently, each with its own round-robin pointer. The block drives the SRAM's `cs`, `we_A`, `add_A`, `data_inA`, `re_B` and `add_B`, and routes `data_outB` back to the requester that issued the read. It sits directly in front of `sram_pdp`, and clients never touch the SRAM pins.

---
 rtl/sram_pdp_pkg.sv | 13 +
 rtl/sram_pdp_arb_rr.sv | 26 ++
 rtl/sram_pdp_arb.sv | 105 ++++++++++
 3 files changed

// File: rtl/sram_pdp_pkg.sv
// Shared types and defaults for the sram_pdp arbiter slice.
// The optional collision forwarding path is enabled by SRAM_ARB_FWD_EN.
package sram_pdp_pkg;
    localparam int NREQ      = 2;
    localparam int DEPTH_DEF = 1024;
    localparam int WIDTH_DEF = 16;

    typedef logic req_id_t;

    function automatic logic [NREQ-1:0] id2oh(req_id_t id);
        return NREQ'(1) << id;
    endfunction
endpackage

// File: rtl/sram_pdp_arb_rr.sv
// Two-way round-robin arbiter with its own pointer. sup[i] withholds the grant
// from candidate i without moving the pointer, so the same winner retries next cycle.
module rr_arb2
    import sram_pdp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] sup,
    output logic [NREQ-1:0] gnt
);
    req_id_t         ptr;
    logic [NREQ-1:0] cand;

    always_comb begin
        cand = req;
        if (&req) cand = id2oh(ptr);
        gnt = rst ? '0 : (cand & ~sup);
    end

    // After a grant to 0 the pointer favours 1, and vice versa.
    always_ff @(posedge clk) begin
        if (rst)       ptr <= 1'b0;
        else if (|gnt) ptr <= gnt[0];
    end
endmodule

// File: rtl/sram_pdp_arb.sv
// Two-client arbiter in front of sram_pdp: independent RR write and read ports.
// SRAM_ARB_FWD_EN: forward same-address write data to a concurrent read instead of stalling it.
module sram_pdp_arb
    import sram_pdp_pkg::*;
#(
    parameter  int depth = DEPTH_DEF,
    parameter  int width = WIDTH_DEF,
    localparam int aw    = $clog2(depth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      wr_req,
    input  logic [NREQ*aw-1:0]   wr_addr,
    input  logic [NREQ*width-1:0] wr_data,
    output logic [NREQ-1:0]      wr_gnt,
    input  logic [NREQ-1:0]      rd_req,
    input  logic [NREQ*aw-1:0]   rd_addr,
    output logic [NREQ-1:0]      rd_gnt,
    output logic [NREQ-1:0]      rd_valid,
    output logic [width-1:0]     rd_data,
    output logic                 cs,
    output logic                 we_A,
    output logic [aw-1:0]        add_A,
    output logic [width-1:0]     data_inA,
    output logic                 re_B,
    output logic [aw-1:0]        add_B,
    input  logic [width-1:0]     data_outB
);
    logic [NREQ-1:0][aw-1:0]    wa, ra;
    logic [NREQ-1:0][width-1:0] wd;
    logic [NREQ-1:0]            rd_sup;
    logic                       pend_v;
    req_id_t                    pend_id;

    assign wa = wr_addr;
    assign wd = wr_data;
    assign ra = rd_addr;

    rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req(wr_req), .sup('0),    .gnt(wr_gnt));
    rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req(rd_req), .sup(rd_sup), .gnt(rd_gnt));

    always_comb begin
        we_A     = |wr_gnt;
        add_A    = '0;
        data_inA = '0;
        for (int i = 0; i < NREQ; i++)
            if (wr_gnt[i]) begin
                add_A    = wa[i];
                data_inA = wd[i];
            end
    end

`ifdef SRAM_ARB_FWD_EN
    assign rd_sup = '0;
`else
    // A read candidate aimed at the word being written waits one cycle so the
    // SRAM itself returns the fresh data.
    always_comb begin
        rd_sup = '0;
        for (int i = 0; i < NREQ; i++)
            rd_sup[i] = we_A && (ra[i] == add_A);
    end
`endif

    always_comb begin
        re_B  = |rd_gnt;
        add_B = '0;
        for (int i = 0; i < NREQ; i++)
            if (rd_gnt[i]) add_B = ra[i];
    end

    assign cs = we_A | re_B;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v  <= 1'b0;
            pend_id <= 1'b0;
        end else begin
            pend_v  <= re_B;
            if (re_B) pend_id <= rd_gnt[1];
        end
    end

    // A pending read is dropped when reset arrives in its return cycle.
    assign rd_valid = (pend_v && !rst) ? id2oh(pend_id) : '0;

`ifdef SRAM_ARB_FWD_EN
    logic             fwd_v;
    logic [width-1:0] fwd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_v    <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_v <= we_A && re_B && (add_A == add_B);
            if (we_A && re_B && (add_A == add_B)) fwd_data <= data_inA;
        end
    end

    assign rd_data = (|rd_valid) ? (fwd_v ? fwd_data : data_outB) : '0;
`else
    assign rd_data = (|rd_valid) ? data_outB : '0;
`endif
endmodule
